unidade_controle_multiciclo: RTL and testbench

Multicycle control FSM that replaces hand-sequenced control strobes for the RV64 datapath (PC, IR, registrador, memoria, ULA, Mux1/Mux2/Mux3).
- Decodes the IR opcode and drives the datapath enables one phase at a time: weIR, wePC, weReg, weMem, sinalMux1, sinalMux2 and a PC-source select.
- Parametrised in execute and memory latency.
- Adds run/step control, illegal-opcode trap and a retired-instruction counter.

---
 rtl/unidade_controle_multiciclo.sv | 139 +++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the RV64 datapath: sequences IR/PC/register/memory
// strobes and mux selects per instruction class, with run control, trap and retire count.
module unidade_controle_multiciclo #(
    parameter int unsigned EXEC_CYCLES      = 1,
    parameter int unsigned MEM_CYCLES       = 1,
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned ZERO_REG_PROTECT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             flag,
    output logic             weIR,
    output logic             wePC,
    output logic             weReg,
    output logic             weMem,
    output logic             sinalMux1,
    output logic             sinalMux2,
    output logic             pc_sel,
    output logic             illegal,
    output logic [3:0]       estado,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned MAXC = (EXEC_CYCLES > MEM_CYCLES) ? EXEC_CYCLES : MEM_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);
    localparam logic [CW-1:0] MEM_LOAD  = CW'(MEM_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_PCUPD  = 4'd6,
        S_TRAP   = 4'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_IALU   = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4
    } class_t;

    state_t           state_q, state_d;
    class_t           class_q, class_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             btaken_q, btaken_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            class_q   <= C_R;
            cnt_q     <= '0;
            btaken_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cnt_q     <= cnt_d;
            btaken_q  <= btaken_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        cnt_d     = cnt_q;
        btaken_d  = btaken_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXEC;
                cnt_d   = EXEC_LOAD;
                case (opcode)
                    7'b0110011: class_d = C_R;
                    7'b0010011: class_d = C_IALU;
                    7'b0000011: class_d = C_LOAD;
                    7'b0100011: class_d = C_STORE;
                    7'b1100011: class_d = C_BRANCH;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    // flag is only sampled here, so pc_sel never sees it combinationally
                    btaken_d = (class_q == C_BRANCH) && flag;
                    case (class_q)
                        C_LOAD, C_STORE: begin
                            state_d = S_MEM;
                            cnt_d   = MEM_LOAD;
                        end
                        C_BRANCH: state_d = S_PCUPD;
                        default:  state_d = S_WB;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MEM: begin
                if (cnt_q == '0) state_d = (class_q == C_LOAD) ? S_WB : S_PCUPD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WB:     state_d = S_PCUPD;
            S_PCUPD: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        weIR      = (state_q == S_FETCH);
        wePC      = (state_q == S_PCUPD);
        weReg     = (state_q == S_WB) && !((ZERO_REG_PROTECT != 0) && (rd == 5'd0));
        weMem     = (state_q == S_MEM) && (class_q == C_STORE) && (cnt_q == '0);
        sinalMux1 = ((state_q == S_EXEC) || (state_q == S_MEM) ||
                     (state_q == S_WB)   || (state_q == S_PCUPD)) &&
                    ((class_q == C_R) || (class_q == C_BRANCH));
        sinalMux2 = (state_q == S_WB) && (class_q == C_LOAD);
        pc_sel    = (state_q == S_PCUPD) && btaken_q;
        illegal   = (state_q == S_TRAP);
        estado    = state_q;
        retired   = retired_q;
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench: dut0 uses default latencies, dut1 uses EXEC=2, MEM=3, CNT_W=4.
module tb_unidade_controle_multiciclo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rstn, run, flag;
    logic [1:0][6:0] opc;
    logic [1:0][4:0] rdv;
    wire  [1:0]      weIR, wePC, weReg, weMem, m1, m2, psel, ill;
    wire  [1:0][3:0] est;
    wire  [31:0]     ret0;
    wire  [3:0]      ret1;

    unidade_controle_multiciclo u_d0 (
        .clock(clk), .reset_n(rstn[0]), .run(run[0]), .opcode(opc[0]), .rd(rdv[0]),
        .flag(flag[0]), .weIR(weIR[0]), .wePC(wePC[0]), .weReg(weReg[0]), .weMem(weMem[0]),
        .sinalMux1(m1[0]), .sinalMux2(m2[0]), .pc_sel(psel[0]), .illegal(ill[0]),
        .estado(est[0]), .retired(ret0)
    );

    unidade_controle_multiciclo #(.EXEC_CYCLES(2), .MEM_CYCLES(3), .CNT_W(4)) u_d1 (
        .clock(clk), .reset_n(rstn[1]), .run(run[1]), .opcode(opc[1]), .rd(rdv[1]),
        .flag(flag[1]), .weIR(weIR[1]), .wePC(wePC[1]), .weReg(weReg[1]), .weMem(weMem[1]),
        .sinalMux1(m1[1]), .sinalMux2(m2[1]), .pc_sel(psel[1]), .illegal(ill[1]),
        .estado(est[1]), .retired(ret1)
    );

    // strobe vector bit order: weIR wePC weReg weMem sinalMux1 sinalMux2 pc_sel illegal
    localparam logic [7:0] S_IR = 8'b1000_0000, S_PC = 8'b0100_0000, S_PCM1 = 8'b0100_1000,
                           S_PCBR = 8'b0100_1010, S_RG = 8'b0010_0000, S_RGM1 = 8'b0010_1000,
                           S_RGLD = 8'b0010_0100, S_MEM = 8'b0001_0000, S_TRP = 8'b0000_0001;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [7:0]  cyc;
        logic [3:0]  est;
        logic [7:0]  s;
        logic [31:0] ret;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  n_cmp = 0;
    int  n_err = 0;

    function automatic logic [7:0] strb(input int i);
        return {weIR[i], wePC[i], weReg[i], weMem[i], m1[i], m2[i], psel[i], ill[i]};
    endfunction

    function automatic logic [31:0] retv(input int i);
        return (i == 0) ? ret0 : {28'd0, ret1};
    endfunction

    task automatic push(input int d, input logic [7:0] c, input logic [3:0] e,
                        input logic [7:0] s, input logic [31:0] r);
        ev_t x;
        x = '{cyc: c, est: e, s: s, ret: r};
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    task automatic monitor();
        logic [7:0] cyc [2];
        logic       ilp [2];
        ev_t        got, want;
        cyc[0] = 8'd0; cyc[1] = 8'd0;
        ilp[0] = 1'b0; ilp[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (weIR[i]) cyc[i] = 8'd1;
                else if (cyc[i] != 8'hFF) cyc[i] = cyc[i] + 8'd1;
                if (weIR[i] | wePC[i] | weReg[i] | weMem[i] | (ill[i] & ~ilp[i])) begin
                    got = '{cyc: cyc[i], est: est[i], s: strb(i), ret: retv(i)};
                    n_cmp++;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        n_err++;
                        $display("FAIL unexpected_event dut%0d: got cyc=%0d est=%0d s=%b ret=%0d, required no event",
                                 i, got.cyc, got.est, got.s, got.ret);
                    end else begin
                        if (i == 0) want = q0.pop_front();
                        else        want = q1.pop_front();
                        if (got !== want) begin
                            n_err++;
                            $display("FAIL event dut%0d: got cyc=%0d est=%0d s=%b ret=%0d, required cyc=%0d est=%0d s=%b ret=%0d",
                                     i, got.cyc, got.est, got.s, got.ret, want.cyc, want.est, want.s, want.ret);
                        end
                    end
                end
                ilp[i] = ill[i];
            end
        end
    endtask

    // Issue one instruction; run is dropped once state drop_st is seen, flag switches to f_after in PCUPD.
    task automatic do_instr(input int d, input logic [6:0] op, input logic [4:0] r,
                            input logic f, input logic f_after, input logic [3:0] drop_st);
        logic dropped, done;
        dropped = 1'b0; done = 1'b0;
        opc[d] = op; rdv[d] = r; flag[d] = f; run[d] = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk); #1;
            if (!dropped && est[d] == drop_st) begin run[d] = 1'b0; dropped = 1'b1; end
            if (est[d] == 4'd6) flag[d] = f_after;
            if (dropped && est[d] == 4'd0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL instr_timeout dut%0d: got no return to IDLE, required IDLE within 60 cycles", d);
            run[d] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        logic seen;
        rstn = '0; run = '0; flag = '0; opc = '0; rdv = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_estado", {28'd0, est[i]}, 32'd0);
            chk("reset_strobes", {24'd0, strb(i)}, 32'd0);
            chk("reset_retired", retv(i), 32'd0);
        end
        @(posedge clk); #1;
        rstn = '1;

        // dut0, default latencies
        push(0, 1, 1, S_IR, 0); push(0, 4, 5, S_RGM1, 0); push(0, 5, 6, S_PCM1, 0);
        do_instr(0, OP_R, 5'd5, 1'b0, 1'b0, 4'd1);
        chk("retired_after_r", ret0, 32'd1);
        push(0, 1, 1, S_IR, 1); push(0, 4, 6, S_PCBR, 1);
        do_instr(0, OP_BR, 5'd0, 1'b1, 1'b0, 4'd1);
        push(0, 1, 1, S_IR, 2); push(0, 4, 6, S_PCM1, 2);
        do_instr(0, OP_BR, 5'd0, 1'b0, 1'b1, 4'd1);
        push(0, 1, 1, S_IR, 3); push(0, 4, 4, S_MEM, 3); push(0, 5, 6, S_PC, 3);
        do_instr(0, OP_ST, 5'd7, 1'b0, 1'b0, 4'd1);
        push(0, 1, 1, S_IR, 4); push(0, 5, 6, S_PCM1, 4);
        do_instr(0, OP_R, 5'd0, 1'b0, 1'b0, 4'd1);
        push(0, 1, 1, S_IR, 5); push(0, 4, 5, S_RG, 5); push(0, 5, 6, S_PC, 5);
        do_instr(0, OP_I, 5'd2, 1'b1, 1'b1, 4'd1);
        push(0, 1, 1, S_IR, 6); push(0, 4, 5, S_RGM1, 6); push(0, 5, 6, S_PCM1, 6);
        do_instr(0, OP_R, 5'd9, 1'b0, 1'b0, 4'd3);
        chk("retired_after_seq", ret0, 32'd7);

        // illegal opcode with run held high
        push(0, 1, 1, S_IR, 7); push(0, 3, 7, S_TRP, 7);
        opc[0] = OP_BAD; run[0] = 1'b1;
        repeat (24) begin @(posedge clk); #1; end
        chk("trap_estado", {28'd0, est[0]}, 32'd7);
        chk("trap_illegal", {31'd0, ill[0]}, 32'd1);
        chk("trap_retired", ret0, 32'd7);
        rstn[0] = 1'b0; run[0] = 1'b0;
        #1;
        chk("async_rst_estado", {28'd0, est[0]}, 32'd0);
        chk("async_rst_illegal", {31'd0, ill[0]}, 32'd0);
        chk("async_rst_retired", ret0, 32'd0);
        @(posedge clk); #1;
        rstn[0] = 1'b1;

        // dut1, EXEC_CYCLES=2 MEM_CYCLES=3 CNT_W=4
        push(1, 1, 1, S_IR, 0); push(1, 8, 5, S_RGLD, 0); push(1, 9, 6, S_PC, 0);
        do_instr(1, OP_LD, 5'd3, 1'b0, 1'b0, 4'd1);
        push(1, 1, 1, S_IR, 1); push(1, 7, 4, S_MEM, 1); push(1, 8, 6, S_PC, 1);
        do_instr(1, OP_ST, 5'd4, 1'b0, 1'b0, 4'd1);
        chk("retired_dut1", retv(1), 32'd2);

        // reset while in MEM: the store pulse must never appear
        push(1, 1, 1, S_IR, 2);
        opc[1] = OP_ST; run[1] = 1'b1; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (est[1] == 4'd4) seen = 1'b1;
        end
        chk("reached_mem", {31'd0, seen}, 32'd1);
        rstn[1] = 1'b0; run[1] = 1'b0;
        #1;
        chk("mem_rst_estado", {28'd0, est[1]}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rstn[1] = 1'b1;
        chk("mem_rst_retired", retv(1), 32'd0);

        // 16 instructions wrap a 4-bit counter back to zero
        for (int k = 0; k < 16; k++) begin
            push(1, 1, 1, S_IR, 32'(k)); push(1, 5, 5, S_RGM1, 32'(k)); push(1, 6, 6, S_PCM1, 32'(k));
            do_instr(1, OP_R, 5'd1, 1'b0, 1'b0, 4'd1);
        end
        chk("retired_wrap", retv(1), 32'd0);

        repeat (3) @(posedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
